// File: rtl/decoder_rr_arbiter_if.sv
// rtl/decoder_rr_arbiter_if.sv - request/grant bundle between requesters and decoder_rr_arbiter
//   req          requester -> arbiter, one bit per requester, held for the whole tenure
//   gnt          arbiter -> requesters, one-hot grant, 0000 when no owner
//   gnt_address0 owner index bit 0 (holds last owner when not enabled)
//   gnt_address1 owner index bit 1 (holds last owner when not enabled)
//   gnt_enable   decoder enable, high only while a grant is held
//   busy         high while a tenure or its dead cycle is in progress
//   timeout      one-cycle pulse on a forced release
interface decoder_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_address0;
    logic       gnt_address1;
    logic       gnt_enable;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        input  gnt, gnt_address0, gnt_address1, gnt_enable, busy, timeout
    );

    modport slave (
        input  req,
        output gnt, gnt_address0, gnt_address1, gnt_enable, busy, timeout
    );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// rtl/decoder_rr_arbiter.sv - 4-way round-robin arbiter driving a 2-to-4 decoder
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; all outputs drop to 0 immediately
//   bus      decoder_rr_arbiter_if.slave: req in; gnt, gnt_address0/1, gnt_enable,
//            busy, timeout out
//   MAX_HOLD max consecutive GRANT cycles per owner (ARB_TIMEOUT_EN only), 2..31
//   CW       hold-counter width, 2**CW > MAX_HOLD
//   Macro ARB_TIMEOUT_EN enables the hold limit; without it tenure is unbounded
//   and timeout is tied 0.
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    decoder_rr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] owner;
    logic [1:0] ptr;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    logic [3:0] eff_req;
    logic       force_release;
    logic       timeout_q;

    // Rotating priority scan: first eligible requester starting at ptr.
    always_comb begin
        pick  = ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && eff_req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            owner <= 2'd0;
            ptr   <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == GRANT)
                owner <= pick;
            // The releasing owner drops to lowest priority for the next round.
            if (state == GRANT && state_nxt == RELEASE)
                ptr <= owner + 2'd1;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = found ? GRANT : IDLE;
            GRANT:   state_nxt = (!bus.req[owner] || force_release) ? RELEASE : GRANT;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode only from registered state/owner, so address, enable and
    // one-hot grant always change together and clear with the async reset.
    always_comb begin
        bus.gnt_enable   = (state == GRANT);
        bus.gnt          = (state == GRANT) ? (4'b0001 << owner) : 4'b0000;
        bus.gnt_address0 = owner[0];
        bus.gnt_address1 = owner[1];
        bus.busy         = (state == GRANT) || (state == RELEASE);
        bus.timeout      = timeout_q;
    end

`ifdef ARB_TIMEOUT_EN
    logic [CW-1:0] hold_cnt;
    logic [3:0]    blocked;

    // hold_cnt counts completed GRANT cycles, so the limit edge is the one
    // ending the MAX_HOLD-th cycle. A voluntary drop on that edge wins.
    assign force_release = (state == GRANT) && bus.req[owner] &&
                           (hold_cnt == CW'(MAX_HOLD - 1));

    // A timed-out owner stays ineligible until it lowers its request.
    assign eff_req = bus.req & ~blocked;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt  <= '0;
            blocked   <= 4'b0000;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= (state == GRANT) ? hold_cnt + CW'(1) : '0;
            timeout_q <= force_release;
            blocked   <= (blocked | (force_release ? (4'b0001 << owner) : 4'b0000)) & bus.req;
        end
    end
`else
    logic unused_cfg;

    assign force_release = 1'b0;
    assign eff_req       = bus.req;
    assign timeout_q     = 1'b0;
    assign unused_cfg    = ^CW'(MAX_HOLD);
`endif

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb/tb_decoder_rr_arbiter.sv - scoreboard bench for decoder_rr_arbiter
module tb_decoder_rr_arbiter;

    localparam int HOLD = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    decoder_rr_arbiter_if bus ();

    decoder_rr_arbiter #(.MAX_HOLD(HOLD), .CW(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] addr;
        logic       en;
        logic       busy;
        logic       to;
    } obs_t;

    obs_t expq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: who owns the resource, whether we are in the dead
    // cycle, and which requester has first claim next round.
    int         m_owner;
    bit         m_dead;
    bit         m_to;
    int         m_prio;
    int         m_last;
    int         m_held;
    logic [3:0] m_blocked;

    function automatic void model_reset();
        m_owner   = -1;
        m_dead    = 0;
        m_to      = 0;
        m_prio    = 0;
        m_last    = 0;
        m_held    = 0;
        m_blocked = 4'b0000;
    endfunction

    function automatic void model_release(input bit forced);
        m_prio  = (m_owner + 1) % 4;
        m_dead  = 1;
        m_to    = forced;
        if (forced) m_blocked[m_owner] = 1'b1;
        m_owner = -1;
    endfunction

    function automatic void model_step(input logic [3:0] r);
        logic [3:0] elig;
        bit         got;
        int         cand;
        if (m_dead) begin
            m_dead = 0;
            m_to   = 0;
        end else if (m_owner >= 0) begin
            if (!r[m_owner]) model_release(0);
`ifdef ARB_TIMEOUT_EN
            else if (m_held == HOLD) model_release(1);
`endif
            else m_held = m_held + 1;
        end else begin
            elig = r & ~m_blocked;
            got  = 0;
            for (int k = 0; k < 4; k++) begin
                cand = (m_prio + k) % 4;
                if (!got && elig[cand]) begin
                    got     = 1;
                    m_owner = cand;
                    m_last  = cand;
                    m_held  = 1;
                end
            end
        end
        m_blocked = m_blocked & r;
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o.gnt  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        o.addr = 2'(m_last);
        o.en   = (m_owner >= 0);
        o.busy = (m_owner >= 0) || m_dead;
        o.to   = m_dead && m_to;
        return o;
    endfunction

    // Requester behaviour: the current owner drops its bit after 'hold' cycles.
    function automatic logic [3:0] polite(input logic [3:0] want, input int hold);
        logic [3:0] r;
        r = want;
        if (m_owner >= 0 && m_held >= hold) r[m_owner] = 1'b0;
        return r;
    endfunction

    // One clock: drive req, let the edge happen, advance the model, queue the
    // expectation for the following negedge. pulse_rst asserts reset 1ns
    // after the edge so the check shows the asynchronous clear.
    task automatic cycle(input logic [3:0] r, input bit hold_rst, input bit pulse_rst);
        if (!hold_rst) reset_n = 1'b1;
        bus.req = r;
        @(posedge clk);
        if (reset_n) model_step(r);
        if (pulse_rst) begin
            #1 reset_n = 1'b0;
            model_reset();
        end
        expq.push_back(model_out());
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {bus.gnt, bus.gnt_address1, bus.gnt_address0, bus.gnt_enable, bus.busy, bus.timeout};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL vec%0d t=%0t: got gnt=%b addr=%0d en=%b busy=%b to=%b, want gnt=%b addr=%0d en=%b busy=%b to=%b",
                         vectors, $time, a.gnt, a.addr, a.en, a.busy, a.to,
                         e.gnt, e.addr, e.en, e.busy, e.to);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] r;
        bit         p;
        model_reset();
        bus.req = 4'b0000;

        // Reset held with all requests high: everything stays 0.
        cycle(4'b1111, 1, 0);
        cycle(4'b1111, 1, 0);

        // First grant one edge after reset release.
        cycle(4'b0001, 0, 0);

        // Full rotation with every requester active, 3-cycle tenures.
        for (int i = 0; i < 26; i++) cycle(polite(4'b1111, 3), 0, 0);

        // Owner 2 holds while req0/req3 rise; its release hands over to 3.
        for (int i = 0; i < 4; i++) cycle(4'b0000, 0, 0);
        for (int i = 0; i < 3; i++) cycle(4'b0100, 0, 0);
        for (int i = 0; i < 3; i++) cycle(4'b1101, 0, 0);
        for (int i = 0; i < 4; i++) cycle(4'b1001, 0, 0);

        // Reset pulse mid-grant of owner 3, then priority restarts at 0.
        for (int i = 0; i < 3; i++) cycle(4'b0000, 0, 0);
        for (int i = 0; i < 3; i++) cycle(4'b1000, 0, 0);
        cycle(4'b1000, 0, 1);
        for (int i = 0; i < 3; i++) cycle(4'b1010, 0, 0);

        // Long hold: bounded only when the hold limit is built in.
        for (int i = 0; i < 3; i++) cycle(4'b0000, 0, 0);
        for (int i = 0; i < 110; i++) cycle(4'b0011, 0, 0);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            r = 4'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            p = ($urandom_range(0, 99) == 0);
            cycle(r, 0, p);
        end

        #1;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
